// File: rtl/dcm_seq_pkg.sv
// Shared constants for the clk25->clk100 DCM lock sequencer.
// State encoding, retry width and counter sizing helper.
package dcm_seq_pkg;

  localparam logic [2:0] ST_RESET_DCM = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  localparam int RETRY_W = 3;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_width(65535, 3, 16);

endpackage

// File: rtl/dcm_lock_sequencer_sync2_ff.sv
// Generic two-flop synchroniser, synchronous active-high reset to 0.
// Used to bring the asynchronous DCM LOCKED into the clk25 domain.
module sync2_ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/dcm_lock_sequencer.sv
// DCM bring-up sequencer: reset pulse, lock wait, stability check, retry.
// Define DCM_AUTO_RELOCK_EN to relock automatically on loss of lock in RUN.
module dcm_lock_sequencer
  import dcm_seq_pkg::*;
#(
  parameter int RST_HOLD_CYCLES    = 3,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int MAX_RETRIES        = 7
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       dcm_locked,
  input  logic       relock_req,
  output logic       dcm_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] retry_cnt
);

  localparam int CW = cnt_width(LOCK_TIMEOUT, RST_HOLD_CYCLES,
                                LOCK_STABLE_CYCLES);

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock counts as the first stable one.
  localparam logic [CW-1:0] STAB_LAST =
    CW'((LOCK_STABLE_CYCLES > 1) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic               locked_s;
  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               dcm_rst_q, dcm_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;

  sync2_ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk(clk25),
    .rst(rst),
    .d  (dcm_locked),
    .q  (locked_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    unique case (1'b1)
      (state_q == ST_RESET_DCM): begin
        if (count_q == HOLD_LAST)
          state_d = ST_WAIT_LOCK;
      end
      (state_q == ST_WAIT_LOCK): begin
        if (locked_s) begin
          state_d = ST_STABLE;
        end else if (count_q == TO_LAST) begin
          if (retry_q >= RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RESET_DCM;
          end
        end
      end
      (state_q == ST_STABLE): begin
        if (!locked_s)
          state_d = ST_WAIT_LOCK;
        else if (count_q == STAB_LAST)
          state_d = ST_RUN;
      end
      (state_q == ST_RUN): begin
        if (relock_req) begin
          state_d = ST_RESET_DCM;
          retry_d = '0;
        end else if (!locked_s) begin
`ifdef DCM_AUTO_RELOCK_EN
          state_d = ST_RESET_DCM;
`else
          state_d = ST_FAIL;
`endif
        end
      end
      (state_q == ST_FAIL): begin
        if (relock_req) begin
          state_d = ST_RESET_DCM;
          retry_d = '0;
        end
      end
      default: state_d = ST_RESET_DCM;
    endcase
  end

  always_comb begin
    count_d = count_q + 1'b1;
    if (state_d != state_q)
      count_d = '0;
    else if (state_q == ST_RUN || state_q == ST_FAIL)
      count_d = count_q;
  end

  // Moore outputs decoded from next state so they move with the state.
  always_comb begin
    dcm_rst_d = (state_d == ST_RESET_DCM);
    ready_d   = (state_d == ST_RUN);
    sys_rst_d = (state_d != ST_RUN);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q   <= ST_RESET_DCM;
      count_q   <= '0;
      retry_q   <= '0;
      dcm_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      retry_q   <= retry_d;
      dcm_rst_q <= dcm_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign dcm_rst   = dcm_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;

endmodule
